// File: rtl/sfx_scheduler_if.sv
// Shared bus of the PONG sound-effect scheduler: the sample-ROM read port
// plus the Audio_Controller write handshake.
interface sfx_scheduler_if;
  logic [1:0]  rom_sel;
  logic [15:0] rom_address;
  logic [15:0] rom_q;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    output rom_sel, rom_address, write_audio_out,
           left_channel_audio_out, right_channel_audio_out,
    input  rom_q, audio_out_allowed
  );

  modport slave (
    input  rom_sel, rom_address, write_audio_out,
           left_channel_audio_out, right_channel_audio_out,
    output rom_q, audio_out_allowed
  );
endinterface

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect scheduler: one shared ROM port, one sample per
// codec tick. Define SFX_VOLUME_EN to add the 2-bit volume input.
module sfx_scheduler #(
  parameter int unsigned DIV       = 1134,  // tick period is DIV+1 clocks; DIV must be >= 3
  parameter int unsigned WALL_LEN  = 8192,
  parameter int unsigned BOINK_LEN = 15436,
  parameter int unsigned WIN_LEN   = 65405
) (
  input  logic                CLOCK_50,
  input  logic                KEY,
  input  logic                req_wall,
  input  logic                req_boink,
  input  logic                req_win,
`ifdef SFX_VOLUME_EN
  input  logic [1:0]          volume,
`endif
  sfx_scheduler_if.master     bus,
  output logic [1:0]          active_sfx,
  output logic                done,
  output logic [7:0]          underrun_cnt
);

  localparam int TW = (DIV < 2) ? 1 : $clog2(DIV + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_ROM, PUSH} state_t;

  state_t         state, state_n;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [15:0]    index;
  logic [31:0]    sample;
  logic [1:0]     req_pri;
  logic           accept;
  logic           capture;
  logic [16:0]    idx_next;
  logic           at_end;
  logic [4:0]     shamt;
  logic           push;

  function automatic logic [16:0] sfx_len(input logic [1:0] s);
    case (s)
      2'd1:    return 17'(WALL_LEN);
      2'd2:    return 17'(BOINK_LEN);
      2'd3:    return 17'(WIN_LEN);
      default: return 17'd0;
    endcase
  endfunction

  assign tick = (tick_cnt == TW'(DIV));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) tick_cnt <= '0;
    else      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) state <= IDLE;
    else      state <= state_n;
  end

  // NOTE: defaults first so no path through the case leaves a latch behind.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE:     if (tick) state_n = FETCH;
      FETCH:    state_n = WAIT_ROM;
      WAIT_ROM: state_n = PUSH;
      PUSH: begin
        if (tick) begin
          state_n = FETCH;                    // sample dropped: underrun
        end else if (bus.audio_out_allowed) begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    req_pri = 2'd0;
    if (req_win)        req_pri = 2'd3;
    else if (req_boink) req_pri = 2'd2;
    else if (req_wall)  req_pri = 2'd1;
  end

  assign accept   = (req_pri != 2'd0) && (req_pri >= active_sfx);
  assign capture  = (state == WAIT_ROM);
  // 17-bit compare so a 65536-sample sound ends without the index wrapping
  assign idx_next = {1'b0, index} + 17'd1;
  assign at_end   = capture && (active_sfx != 2'd0) && (idx_next == sfx_len(active_sfx));

`ifdef SFX_VOLUME_EN
  assign shamt = 5'd11 + {3'd0, volume};
`else
  assign shamt = 5'd14;
`endif

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      active_sfx   <= 2'd0;
      index        <= 16'd0;
      done         <= 1'b0;
      sample       <= 32'd0;
      underrun_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      // a new request outranks both the index advance and the end-of-sound
      if (accept) begin
        active_sfx <= req_pri;
        index      <= 16'd0;
      end else if (at_end) begin
        active_sfx <= 2'd0;
        index      <= 16'd0;
        done       <= 1'b1;
      end else if (capture && active_sfx != 2'd0) begin
        index      <= idx_next[15:0];
      end

      if (capture)
        sample <= (active_sfx != 2'd0) ? (32'(bus.rom_q) << shamt) : 32'd0;

      if (state == PUSH && tick && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  assign bus.rom_sel                 = active_sfx;
  assign bus.rom_address             = index;
  assign bus.write_audio_out         = push;
  assign bus.left_channel_audio_out  = sample;
  assign bus.right_channel_audio_out = sample;

endmodule
